// File: rtl/waveform_acq.sv
// waveform_acq: captures pretrigger+posttrigger waveforms into a circular buffer and emits one header per capture.
module waveform_acq #(
  parameter int P_ADR_WIDTH = 12,
  parameter int P_PRE_WIDTH = 5,
  parameter int P_MAX_LEN   = 1024,
  parameter int P_LTC_WIDTH = 48
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [11:0]                          adc_stream,
  input  logic [7:0]                           discr_stream,
  input  logic                                 trig,
  input  logic [1:0]                           trig_src,
  input  logic                                 thresh_tot,
  input  logic                                 discr_tot,
  input  logic [P_LTC_WIDTH-1:0]               ltc,
  input  logic [P_PRE_WIDTH-1:0]               pre_conf,
  input  logic [11:0]                          post_conf,
  input  logic                                 tot_ext_en,
  input  logic                                 buf_afull,
  input  logic                                 hdr_full,
  output logic                                 buf_wr_en,
  output logic [P_ADR_WIDTH-1:0]               buf_wr_addr,
  output logic [21:0]                          buf_wr_data,
  output logic                                 hdr_wr_en,
  output logic [2*P_ADR_WIDTH+P_LTC_WIDTH+2:0] hdr_data,
  output logic                                 busy,
  output logic [15:0]                          drop_cnt
);
  localparam int DEPTH = 2 ** P_PRE_WIDTH;
  typedef enum logic [1:0] {IDLE, CAPTURE, HDR} state_t;
  state_t state, state_nxt;
  logic [19:0] dly [DEPTH];
  logic [P_ADR_WIDTH-1:0] wr_ptr, start_addr, stop_addr;
  logic [P_PRE_WIDTH-1:0] pre_q;
  logic [P_LTC_WIDTH-1:0] ltc_q;
  logic [1:0] src_q;
  logic [12:0] n, last_idx, len_raw, len_clip;
  logic ext_q, ext_flag, accept, drop, tot, ext_go, last;
  assign len_raw  = 13'(pre_conf) + 13'(post_conf) + 13'd1;
  assign len_clip = len_raw > 13'(P_MAX_LEN) ? 13'(P_MAX_LEN) : len_raw;
  assign accept   = state == IDLE && trig && en && !buf_afull && !hdr_full;
  assign drop     = trig && !accept;
  assign tot      = thresh_tot || discr_tot;
  // extension starts only on the nominal last word and never past the hard cap
  assign ext_go   = state == CAPTURE && !ext_q && n == last_idx && tot_ext_en && tot && n != 13'(P_MAX_LEN - 1);
  assign last     = n == 13'(P_MAX_LEN - 1) || (ext_q ? !tot : (n == last_idx && !ext_go));
  assign busy     = state != IDLE;
  assign buf_wr_addr = buf_wr_en ? wr_ptr : '0;
  assign buf_wr_data = buf_wr_en ? {last, n == '0, dly[pre_q]} : '0;
  assign hdr_data    = hdr_wr_en ? {ext_flag, src_q, ltc_q, stop_addr, start_addr} : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    buf_wr_en = 1'b0;
    hdr_wr_en = 1'b0;
    case (state)
      IDLE:    state_nxt = accept ? CAPTURE : IDLE;
      CAPTURE: begin
        buf_wr_en = 1'b1;
        state_nxt = last ? HDR : CAPTURE;
      end
      HDR: begin
        hdr_wr_en = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // dly[i] holds the input from i+1 cycles ago, so dly[pre_q] lines up with word 0 at t+1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {discr_stream, adc_stream};
      for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      start_addr <= '0;
      stop_addr  <= '0;
      pre_q      <= '0;
      ltc_q      <= '0;
      src_q      <= '0;
      n          <= '0;
      last_idx   <= '0;
      ext_q      <= 1'b0;
      ext_flag   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (accept) begin
        start_addr <= wr_ptr;
        src_q      <= trig_src;
        ltc_q      <= ltc;
        pre_q      <= pre_conf;
        last_idx   <= len_clip - 13'd1;
        n          <= '0;
        ext_q      <= 1'b0;
        ext_flag   <= 1'b0;
      end
      if (buf_wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        n      <= n + 13'd1;
        if (ext_go) begin
          ext_q    <= 1'b1;
          ext_flag <= 1'b1;
        end
        if (last) stop_addr <= wr_ptr;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
endmodule

// File: tb/tb_waveform_acq.sv
// tb_waveform_acq: directed checks of waveform_acq capture, TOT extension, drops, wrap and reset abort.
module tb_waveform_acq;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, trig = 1'b0, thresh_tot = 1'b0, discr_tot = 1'b0;
  logic tot_ext_en = 1'b0, buf_afull = 1'b0, hdr_full = 1'b0;
  logic [11:0] adc_stream = '0, post_conf = '0;
  logic [7:0] discr_stream = '0;
  logic [1:0] trig_src = '0;
  logic [47:0] ltc = '0;
  logic [4:0] pre_conf = '0;
  logic buf_wr_en, hdr_wr_en, busy;
  logic [11:0] buf_wr_addr;
  logic [21:0] buf_wr_data;
  logic [74:0] hdr_data;
  logic [15:0] drop_cnt;
  int checks = 0, errors = 0, ramp = 0, cyc = 0, trig_val = 0, trig_cyc = 0;
  logic [47:0] ltc_at;
  logic [11:0] wa[$];
  logic [21:0] wd[$];
  int wc[$], hc[$];
  logic [74:0] hq[$];

  waveform_acq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_stream(adc_stream), .discr_stream(discr_stream),
    .trig(trig), .trig_src(trig_src), .thresh_tot(thresh_tot), .discr_tot(discr_tot), .ltc(ltc),
    .pre_conf(pre_conf), .post_conf(post_conf), .tot_ext_en(tot_ext_en), .buf_afull(buf_afull),
    .hdr_full(hdr_full), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .hdr_wr_en(hdr_wr_en), .hdr_data(hdr_data), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (buf_wr_en) begin
      wa.push_back(buf_wr_addr);
      wd.push_back(buf_wr_data);
      wc.push_back(cyc);
    end
    if (hdr_wr_en) begin
      hq.push_back(hdr_data);
      hc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ramp++;
    adc_stream   = 12'(ramp);
    discr_stream = 8'(ramp) ^ 8'hA5;
    ltc          = {16'hBEEF, 32'(ramp)};
  endtask

  task automatic fire(input int pre, input int post, input int tot_cyc, input int trig2_at, input int limit);
    wa.delete(); wd.delete(); wc.delete(); hq.delete(); hc.delete();
    pre_conf   = 5'(pre);
    post_conf  = 12'(post);
    trig       = 1'b1;
    thresh_tot = tot_cyc > 0;
    trig_val   = ramp;
    trig_cyc   = cyc;
    ltc_at     = ltc;
    for (int i = 1; i <= limit && hq.size() == 0; i++) begin
      tick();
      trig       = i == trig2_at;
      thresh_tot = i < tot_cyc;
      if (i == 2) begin
        pre_conf  = 5'd31;
        post_conf = 12'd0;
      end
    end
    tick();
    trig       = 1'b0;
    thresh_tot = 1'b0;
    check("hdr_seen", hq.size(), 1);
  endtask

  task automatic verify(input int n, input int start, input int pre, input logic ext);
    int bad = 0;
    check("word_count", wa.size(), n);
    for (int k = 0; k < wa.size(); k++) begin
      int v = trig_val - pre + k;
      logic [21:0] e = {k == n - 1, k == 0, v[7:0] ^ 8'hA5, v[11:0]};
      if (wa[k] != 12'(start + k) || wd[k] != e || wc[k] != trig_cyc + 1 + k) bad++;
    end
    check("word_seq", bad, 0);
    if (hq.size() > 0) begin
      check("hdr_data", hq[0], {ext, trig_src, ltc_at, 12'(start + n - 1), 12'(start)});
      check("hdr_cycle", hc[0], trig_cyc + 1 + n);
    end
    check("idle_after", busy, 0);
  endtask

  task automatic drop_try();
    wa.delete();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (3) tick();
    check("no_capture", {busy, 32'(wa.size())}, 0);
  endtask

  initial begin
    repeat (5) tick();
    check("rst_ctl", {buf_wr_en, hdr_wr_en, busy, buf_wr_addr, drop_cnt}, 0);
    check("rst_data", {buf_wr_data, hdr_data}, 0);
    rst_n = 1'b1;
    while (ramp != 100) tick();
    trig_src = 2'd1;
    fire(4, 10, 0, -1, 100);
    verify(15, 0, 4, 1'b0);
    tot_ext_en = 1'b1;
    trig_src   = 2'd2;
    fire(0, 5, 20, -1, 100);
    verify(20, 15, 0, 1'b1);
    trig_src = 2'd3;
    fire(0, 5, 1000000, -1, 1200);
    verify(1024, 35, 0, 1'b1);
    tot_ext_en = 1'b0;
    trig_src   = 2'd0;
    fire(0, 9, 0, 3, 100);
    verify(10, 1059, 0, 1'b0);
    check("drop_in_capture", drop_cnt, 1);
    buf_afull = 1'b1;
    drop_try();
    buf_afull = 1'b0;
    check("drop_afull", drop_cnt, 2);
    hdr_full = 1'b1;
    drop_try();
    hdr_full = 1'b0;
    check("drop_hdr_full", drop_cnt, 3);
    en = 1'b0;
    drop_try();
    en = 1'b1;
    check("drop_disabled", drop_cnt, 4);
    fire(0, 2000, 0, -1, 1200);
    verify(1024, 1069, 0, 1'b0);
    fire(0, 2000, 0, -1, 1200);
    verify(1024, 2093, 0, 1'b0);
    fire(0, 972, 0, -1, 1200);
    verify(973, 3117, 0, 1'b0);
    trig_src = 2'd2;
    fire(2, 9, 0, -1, 100);
    verify(12, 4090, 2, 1'b0);
    wa.delete(); hq.delete();
    pre_conf  = 5'd4;
    post_conf = 12'd10;
    trig      = 1'b1;
    tick();
    trig = 1'b0;
    repeat (5) tick();
    check("busy_mid", {busy, buf_wr_en}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("abort_ctl", {buf_wr_en, hdr_wr_en, busy, buf_wr_addr, drop_cnt}, 0);
    check("abort_data", {buf_wr_data, hdr_data}, 0);
    repeat (20) tick();
    check("abort_no_hdr", hq.size(), 0);
    rst_n = 1'b1;
    repeat (40) tick();
    trig_src = 2'd1;
    fire(4, 10, 0, -1, 100);
    verify(15, 0, 4, 1'b0);
    en   = 1'b0;
    trig = 1'b1;
    repeat (65540) tick();
    trig = 1'b0;
    tick();
    check("drop_saturate", drop_cnt, 16'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
